i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/audio_pkg.sv | 20 ++
 rtl/i2s_tx.sv | 82 ++++++++
 2 files changed

// File: rtl/audio_pkg.sv
// Shared audio framing constants and sample-pair type for the I2S datapath.
// Frame geometry is derived from these values so a single edit retimes every user.
package audio_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int MCLK_PER_BCLK  = 4;
  localparam int BCLK_PER_FRAME = 64;
  localparam int SLOT_W         = 32;

  localparam int PH_W       = $clog2(MCLK_PER_BCLK * BCLK_PER_FRAME);
  localparam int BCLK_BIT   = $clog2(MCLK_PER_BCLK) - 1;
  localparam int SLOT_IDX_W = $clog2(BCLK_PER_FRAME);
  localparam int POS_W      = $clog2(SLOT_W);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;

endpackage

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: free-running phase counter, outputs are registered decodes (1 cycle latency).
// No backpressure: upstream is paced by sample_req and must hold data steady until the frame-end latch.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_l,
  input  logic [WIDTH-1:0] data_r,
  input  logic             mute,
  output logic             sample_req,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             i2s_sdata
);

  typedef struct packed {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } pair_t;

  logic [PH_W-1:0]       ph_q, ph_d;
  pair_t                 hold_q, hold_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  sample_req_q, sample_req_d;
  logic [SLOT_IDX_W-1:0] slot;
  logic [POS_W-1:0]      pos;
  logic [WIDTH-1:0]      word;

  always_comb begin
    ph_d   = ph_q + PH_W'(1);
    hold_d = hold_q;
    // Latch on the last phase so the new pair is stable from the frame's first slot.
    if (ph_q == '1) begin
      hold_d = mute ? '0 : {data_l, data_r};
    end

    slot = ph_q[PH_W-1 -: SLOT_IDX_W];
    pos  = slot[POS_W-1:0];
    word = slot[SLOT_IDX_W-1] ? hold_q.r : hold_q.l;

    // Position 0 is the one-bclk I2S delay; positions past WIDTH are zero padding.
    sdata_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(pos) == WIDTH - i) begin
        sdata_d = word[i];
      end
    end

    bclk_d       = ph_q[BCLK_BIT];
    lrclk_d      = ph_q[PH_W-1];
    sample_req_d = (ph_q == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ph_q         <= '0;
      hold_q       <= '0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      sample_req_q <= 1'b0;
    end else begin
      ph_q         <= ph_d;
      hold_q       <= hold_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      sample_req_q <= sample_req_d;
    end
  end

  assign sample_req = sample_req_q;
  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;

endmodule
